cold_buffer_filler: RTL
=======================

COLD_BUFFER_FILLER -- requirements
Module: cold_buffer_filler

Interface
REQ-001 Parameters: DW, default 32, word width in bits; BEAT_WORDS, default 16, words per memory beat; ROW_WORDS, default 256, words per cold-buffer row; ROWS, default 32, cold-buffer depth.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; launches a fill job; sampled only in IDLE.
REQ-005 base_idx  input  5  first cold-buffer row to write; sampled with start.
REQ-006 num_rows  input  6  rows to fill, range 0..32; sampled with start.
REQ-007 mem_valid  input  1  memory beat valid.
REQ-008 mem_data  input  BEAT_WORDS*DW  beat payload; word j occupies bits [j*DW +: DW].
REQ-009 mem_ready  output  1  filler accepts a beat.
REQ-010 cb_in  output  DW x ROW_WORDS array  assembled row to the cold buffer.
REQ-011 cb_idx  output  5  target cold-buffer row.
REQ-012 cb_write_en  output  1  one-cycle cold-buffer write strobe.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM has four states: IDLE, FILL, WRITE and DONE.
REQ-016 IDLE: on start with num_rows != 0, latch base_idx and num_rows, clear the beat and row counters, and go to FILL; on start with num_rows == 0, go to DONE and write nothing.
REQ-017 FILL: mem_ready = 1, combinational on state only; a beat is accepted in any cycle with mem_valid && mem_ready.
REQ-018 An accepted beat k (0..ROW_WORDS/BEAT_WORDS-1, i.e. 0..15) is stored into row words [k*BEAT_WORDS +: BEAT_WORDS], keeping word order; the beat counter then increments.
REQ-019 After beat 15 is accepted, the FSM goes to WRITE on the next edge.
REQ-020 FILL with mem_valid low: hold all state, no timeout.
REQ-021 WRITE lasts exactly one cycle, with cb_write_en = 1, cb_idx = (base_idx + row_cnt) mod 32 (wraps past 31 to 0), and cb_in = the registered row.
REQ-022 mem_ready = 0 in WRITE, DONE and IDLE, so no beat is accepted there.
REQ-023 Leaving WRITE: if row_cnt == num_rows-1, go to DONE; otherwise increment row_cnt, clear the beat counter and go to FILL.
REQ-024 DONE lasts one cycle with done = 1, then returns to IDLE.
REQ-025 start outside IDLE is ignored.
REQ-026 Latency: cb_write_en is asserted exactly 1 cycle after the edge on which the last beat of a row is accepted.
REQ-027 Minimum row period: 17 cycles (16 beats + 1 write).
REQ-028 cb_in is held stable from WRITE until the next row's first beat overwrites it; the ColdBuffer samples it only under cb_write_en.

Reset
REQ-029 While rst = 0 (asynchronous assertion):
- state = IDLE;
- all counters = 0;
- mem_ready, cb_write_en and done = 0;
- cb_idx = 0;
- busy = 0.
REQ-030 The row storage is not reset; cb_in is don't-care until the first write.
REQ-031 Reset mid-job abandons the job: no further cb_write_en, no done pulse, and a partially assembled row is discarded.

Structure
REQ-032 A shared package holds:
- DW, BEAT_WORDS, ROW_WORDS, ROWS and IDX_W = 5;
- the state enum;
- derived BEATS_PER_ROW = ROW_WORDS / BEAT_WORDS.
REQ-033 The block is a single module with no sub-module; the row register is an array of BEATS_PER_ROW slices written by the beat index.

Verification
REQ-034 base_idx=0, num_rows=1, 16 back-to-back beats with word value = global word index -> one cb_write_en 1 cycle after beat 15, cb_idx=0, cb_in[i]=i for i=0..255, done 1 cycle later, busy then low.
REQ-035 base_idx=30, num_rows=4 -> cb_idx sequence 30, 31, 0, 1; exactly 4 write strobes; one done.
REQ-036 mem_valid toggled randomly (~50%) -> data identical to the back-to-back case; mem_ready = 0 during WRITE; no beat lost or duplicated.
REQ-037 num_rows=0 -> done 1 cycle after start, no cb_write_en, mem_ready never high.
REQ-038 start pulsed again during FILL -> ignored; row count unchanged.
REQ-039 rst asserted after beat 7 of row 2 -> all outputs immediately 0; after release, a new job with num_rows=1 writes cleanly to its base_idx.

Source files
------------

// File: rtl/cold_buffer_filler_pkg.sv
// Shared sizing and state encoding for the cold-buffer row filler.
package cold_buffer_filler_pkg;

    localparam int DW            = 32;
    localparam int BEAT_WORDS    = 16;
    localparam int ROW_WORDS     = 256;
    localparam int ROWS          = 32;
    localparam int IDX_W         = 5;
    localparam int BEATS_PER_ROW = ROW_WORDS / BEAT_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/cold_buffer_filler.sv
// Assembles memory beats into full rows and writes them to consecutive cold-buffer rows.
// Write strobe one cycle after a row's last beat; mem_ready only in FILL, mem_valid low just stalls.
module cold_buffer_filler #(
    parameter int DW         = cold_buffer_filler_pkg::DW,
    parameter int BEAT_WORDS = cold_buffer_filler_pkg::BEAT_WORDS,
    parameter int ROW_WORDS  = cold_buffer_filler_pkg::ROW_WORDS,
    parameter int ROWS       = cold_buffer_filler_pkg::ROWS
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [cold_buffer_filler_pkg::IDX_W-1:0] base_idx,
    input  logic [cold_buffer_filler_pkg::IDX_W:0]   num_rows,
    input  logic                                     mem_valid,
    input  logic [BEAT_WORDS*DW-1:0]                 mem_data,
    output logic                                     mem_ready,
    output logic [DW-1:0]                            cb_in [ROW_WORDS],
    output logic [cold_buffer_filler_pkg::IDX_W-1:0] cb_idx,
    output logic                                     cb_write_en,
    output logic                                     busy,
    output logic                                     done
);
    import cold_buffer_filler_pkg::*;

    localparam int BPR = ROW_WORDS / BEAT_WORDS;
    localparam int BW  = $clog2(BPR);
    localparam int CW  = IDX_W + 1;

    state_t                    r_state;
    logic [BW-1:0]             r_beat_cnt;
    logic [CW-1:0]             r_row_cnt;
    logic [CW-1:0]             r_num_rows;
    logic [IDX_W-1:0]          r_base;
    logic [BEAT_WORDS*DW-1:0]  r_row [BPR];

    logic                      w_accept;
    logic                      w_last_beat;
    logic                      w_last_row;
    logic [CW-1:0]             w_idx_sum;

    assign mem_ready   = (r_state == FILL);
    assign cb_write_en = (r_state == WRITE);
    assign done        = (r_state == DONE);
    assign busy        = (r_state != IDLE);

    assign w_accept    = mem_valid && mem_ready;
    assign w_last_beat = (r_beat_cnt == BW'(BPR - 1));
    assign w_last_row  = (r_row_cnt == r_num_rows - CW'(1));

    // One spare bit keeps the sum exact before folding back into the row range.
    assign w_idx_sum   = CW'(r_base) + r_row_cnt;
    assign cb_idx      = IDX_W'(w_idx_sum % CW'(ROWS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
            r_num_rows <= '0;
            r_base     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_rows == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_base     <= base_idx;
                            r_num_rows <= num_rows;
                            r_beat_cnt <= '0;
                            r_row_cnt  <= '0;
                            r_state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                        if (w_last_beat) begin
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (w_last_row) begin
                        r_state <= DONE;
                    end else begin
                        r_row_cnt  <= r_row_cnt + CW'(1);
                        r_beat_cnt <= '0;
                        r_state    <= FILL;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Row storage is data-path only and carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_row[r_beat_cnt] <= mem_data;
        end
    end

    for (genvar i = 0; i < ROW_WORDS; i++) begin : g_cb_in
        assign cb_in[i] = r_row[i / BEAT_WORDS][(i % BEAT_WORDS) * DW +: DW];
    end

endmodule
